// File: rtl/uart_apb_fifo_if.sv
// APB3 slave bus bundle for uart_apb_fifo; the bench drives the master side.
interface uart_apb_fifo_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] padd;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (output psel, penable, pwrite, padd, pwdata,
                    input  prdata, pready, pslverr);
    modport slave  (input  psel, penable, pwrite, padd, pwdata,
                    output prdata, pready, pslverr);
endinterface

// File: rtl/uart_apb_fifo.sv
// APB-attached UART with TX/RX FIFOs, programmable baud divisor and level interrupt.
// Optional parity: define UART_APB_FIFO_PARITY_EN to add CTRL[5] parity_en / CTRL[6] odd.

module uart_apb_fifo_sfifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    // A pop frees the slot a simultaneous push needs; a push never feeds a same-cycle pop.
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | i_pop);
    assign o_rdata = r_mem[r_rptr];

    // NOTE: storage has no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

module uart_apb_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic            pclk,
    input  logic            rst,
    uart_apb_fifo_if.slave  apb,
    input  logic            ser_in,
    output logic            ser_out,
    output logic            irq
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_e;

    localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

    logic [6:0]        r_ctrl;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  r_baud_cnt;
    logic              r_ovr, r_fe, r_pe, r_irq;
    logic              w_tick;
    logic              w_tx_en, w_rx_en, w_rx_ie, w_tx_ie, w_err_ie;
    logic              w_parity_en, w_par_odd;

    logic              w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    logic [DATA_W-1:0] w_tx_rdata;
    logic              w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
    logic [DATA_W-1:0] w_rx_rdata;

    uart_state_e       r_tx_state, w_tx_state_nxt;
    logic [DATA_W-1:0] r_tx_shift, w_tx_shift_nxt;
    logic              r_tx_par, w_tx_par_nxt;
    logic [3:0]        r_tx_tcnt, w_tx_tcnt_nxt;
    logic [2:0]        r_tx_bcnt, w_tx_bcnt_nxt;
    logic              r_ser_out, w_ser_out_nxt;

    uart_state_e       r_rx_state, w_rx_state_nxt;
    logic [DATA_W-1:0] r_rx_shift, w_rx_shift_nxt;
    logic              r_rx_perr, w_rx_perr_nxt;
    logic [3:0]        r_rx_tcnt, w_rx_tcnt_nxt;
    logic [2:0]        r_rx_bcnt, w_rx_bcnt_nxt;
    logic [2:0]        r_rx_sync;
    logic              w_rx_in, w_rx_fall;
    logic              w_set_ovr, w_set_fe, w_set_pe;

    logic              w_access, w_addr_ok, w_pslverr, w_w1c, w_div_we, w_ctrl_we;
    logic [31:0]       w_prdata, w_status;
    logic              w_unused;

    assign w_tx_en  = r_ctrl[0];
    assign w_rx_en  = r_ctrl[1];
    assign w_rx_ie  = r_ctrl[2];
    assign w_tx_ie  = r_ctrl[3];
    assign w_err_ie = r_ctrl[4];
`ifdef UART_APB_FIFO_PARITY_EN
    assign w_parity_en = r_ctrl[5];
    assign w_par_odd   = r_ctrl[6];
`else
    assign w_parity_en = 1'b0;
    assign w_par_odd   = 1'b0;
`endif
    assign w_unused = ^{apb.pwdata, r_ctrl};

    uart_apb_fifo_sfifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(pclk), .rst(rst), .i_push(w_tx_push), .i_wdata(apb.pwdata[DATA_W-1:0]),
        .i_pop(w_tx_pop), .o_rdata(w_tx_rdata), .o_full(w_tx_full), .o_empty(w_tx_empty));

    uart_apb_fifo_sfifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(pclk), .rst(rst), .i_push(w_rx_push), .i_wdata(r_rx_shift),
        .i_pop(w_rx_pop), .o_rdata(w_rx_rdata), .o_full(w_rx_full), .o_empty(w_rx_empty));

    // The divisor is only picked up on reload, so a DIV write never shortens the running period.
    assign w_tick = (r_baud_cnt == '0);
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) r_baud_cnt <= '0;
        else     r_baud_cnt <= w_tick ? r_div : r_baud_cnt - DIV_W'(1);
    end

    // ---------------- APB decode ----------------
    assign w_access  = apb.psel & apb.penable;
    assign w_addr_ok = (apb.padd[31:4] == '0) && (apb.padd[1:0] == 2'b00);
    assign w_status  = {24'd0, (r_tx_state != S_IDLE), r_pe, r_fe, r_ovr,
                        w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_prdata  = '0;
        w_pslverr = 1'b0;
        w_tx_push = 1'b0;
        w_rx_pop  = 1'b0;
        w_w1c     = 1'b0;
        w_div_we  = 1'b0;
        w_ctrl_we = 1'b0;
        if (w_access) begin
            if (!w_addr_ok) begin
                w_pslverr = 1'b1;
            end else begin
                case (apb.padd[3:2])
                    2'd0: if (apb.pwrite) begin
                            if (w_tx_full && !w_tx_pop) w_pslverr = 1'b1;
                            else                        w_tx_push = 1'b1;
                        end else begin
                            if (w_rx_empty) w_pslverr = 1'b1;
                            else begin
                                w_rx_pop = 1'b1;
                                w_prdata = 32'(w_rx_rdata);
                            end
                        end
                    2'd1: if (apb.pwrite) w_w1c = 1'b1;    else w_prdata = w_status;
                    2'd2: if (apb.pwrite) w_div_we = 1'b1; else w_prdata = 32'(r_div);
                    default: if (apb.pwrite) w_ctrl_we = 1'b1; else w_prdata = 32'(r_ctrl);
                endcase
            end
        end
    end

    assign apb.pready  = w_access & ~rst;
    assign apb.pslverr = w_pslverr & ~rst;
    assign apb.prdata  = rst ? 32'd0 : w_prdata;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_ctrl <= '0;
            r_div  <= '0;
            r_ovr  <= 1'b0;
            r_fe   <= 1'b0;
            r_pe   <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
`ifdef UART_APB_FIFO_PARITY_EN
            if (w_ctrl_we) r_ctrl <= apb.pwdata[6:0];
`else
            if (w_ctrl_we) r_ctrl <= {2'b00, apb.pwdata[4:0]};
`endif
            if (w_div_we) r_div <= apb.pwdata[DIV_W-1:0];
            r_ovr <= w_set_ovr | (r_ovr & ~(w_w1c & apb.pwdata[4]));
            r_fe  <= w_set_fe  | (r_fe  & ~(w_w1c & apb.pwdata[5]));
            r_pe  <= w_set_pe  | (r_pe  & ~(w_w1c & apb.pwdata[6]));
            r_irq <= (w_rx_ie & ~w_rx_empty) | (w_tx_ie & w_tx_empty) |
                     (w_err_ie & (r_ovr | r_fe | r_pe));
        end
    end
    assign irq = r_irq;

    // ---------------- Transmitter ----------------
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_par_nxt   = r_tx_par;
        w_tx_tcnt_nxt  = r_tx_tcnt;
        w_tx_bcnt_nxt  = r_tx_bcnt;
        w_ser_out_nxt  = r_ser_out;
        w_tx_pop       = 1'b0;
        if (r_tx_state == S_IDLE) begin
            // tx_en is only looked at here, so clearing it lets a running frame finish.
            if (w_tick && w_tx_en && !w_tx_empty) begin
                w_tx_pop       = 1'b1;
                w_tx_shift_nxt = w_tx_rdata;
                w_tx_par_nxt   = (^w_tx_rdata) ^ w_par_odd;
                w_tx_tcnt_nxt  = '0;
                w_tx_state_nxt = S_START;
                w_ser_out_nxt  = 1'b0;
            end
        end else if (w_tick) begin
            w_tx_tcnt_nxt = r_tx_tcnt + 4'd1;
            if (r_tx_tcnt == 4'd15) begin
                case (r_tx_state)
                    S_START: begin
                        w_tx_state_nxt = S_DATA;
                        w_tx_bcnt_nxt  = '0;
                        w_ser_out_nxt  = r_tx_shift[0];
                    end
                    S_DATA: begin
                        if (r_tx_bcnt == LAST_BIT) begin
                            w_tx_state_nxt = w_parity_en ? S_PARITY : S_STOP;
                            w_ser_out_nxt  = w_parity_en ? r_tx_par : 1'b1;
                        end else begin
                            w_tx_bcnt_nxt  = r_tx_bcnt + 3'd1;
                            w_tx_shift_nxt = r_tx_shift >> 1;
                            w_ser_out_nxt  = r_tx_shift[1];
                        end
                    end
                    S_PARITY: begin
                        w_tx_state_nxt = S_STOP;
                        w_ser_out_nxt  = 1'b1;
                    end
                    default: begin
                        w_tx_state_nxt = S_IDLE;
                        w_ser_out_nxt  = 1'b1;
                    end
                endcase
            end
        end
    end

    // ser_out is a flop loaded with the next bit, so it only changes at bit boundaries.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_tx_state <= S_IDLE;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_tcnt  <= '0;
            r_tx_bcnt  <= '0;
            r_ser_out  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_par   <= w_tx_par_nxt;
            r_tx_tcnt  <= w_tx_tcnt_nxt;
            r_tx_bcnt  <= w_tx_bcnt_nxt;
            r_ser_out  <= w_ser_out_nxt;
        end
    end
    assign ser_out = r_ser_out;

    // ---------------- Receiver ----------------
    assign w_rx_in   = r_rx_sync[1];
    assign w_rx_fall = r_rx_sync[2] & ~r_rx_sync[1];

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_perr_nxt  = r_rx_perr;
        w_rx_tcnt_nxt  = r_rx_tcnt;
        w_rx_bcnt_nxt  = r_rx_bcnt;
        w_rx_push      = 1'b0;
        w_set_ovr      = 1'b0;
        w_set_fe       = 1'b0;
        w_set_pe       = 1'b0;
        if (r_rx_state == S_IDLE) begin
            if (w_rx_en && w_rx_fall) begin
                w_rx_state_nxt = S_START;
                w_rx_tcnt_nxt  = '0;
                w_rx_perr_nxt  = 1'b0;
            end
        end else if (w_tick) begin
            w_rx_tcnt_nxt = r_rx_tcnt + 4'd1;
            if (r_rx_tcnt == 4'd7) begin
                case (r_rx_state)
                    S_START:  if (w_rx_in) w_rx_state_nxt = S_IDLE;
                    S_DATA:   w_rx_shift_nxt = {w_rx_in, r_rx_shift[DATA_W-1:1]};
                    S_PARITY: w_rx_perr_nxt  = ((^r_rx_shift) ^ w_par_odd) != w_rx_in;
                    S_STOP: begin
                        // Finish at mid-stop so a back-to-back start edge is not missed.
                        w_rx_state_nxt = S_IDLE;
                        if (!w_rx_in)                    w_set_fe  = 1'b1;
                        else if (r_rx_perr)              w_set_pe  = 1'b1;
                        else if (w_rx_full && !w_rx_pop) w_set_ovr = 1'b1;
                        else                             w_rx_push = 1'b1;
                    end
                    default: w_rx_state_nxt = S_IDLE;
                endcase
            end else if (r_rx_tcnt == 4'd15) begin
                case (r_rx_state)
                    S_START: begin
                        w_rx_state_nxt = S_DATA;
                        w_rx_bcnt_nxt  = '0;
                    end
                    S_DATA: begin
                        if (r_rx_bcnt == LAST_BIT) w_rx_state_nxt = w_parity_en ? S_PARITY : S_STOP;
                        else                       w_rx_bcnt_nxt  = r_rx_bcnt + 3'd1;
                    end
                    S_PARITY: w_rx_state_nxt = S_STOP;
                    default:  ;
                endcase
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_rx_sync  <= 3'b111;
            r_rx_state <= S_IDLE;
            r_rx_shift <= '0;
            r_rx_perr  <= 1'b0;
            r_rx_tcnt  <= '0;
            r_rx_bcnt  <= '0;
        end else begin
            r_rx_sync  <= {r_rx_sync[1:0], ser_in};
            r_rx_state <= w_rx_state_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_perr  <= w_rx_perr_nxt;
            r_rx_tcnt  <= w_rx_tcnt_nxt;
            r_rx_bcnt  <= w_rx_bcnt_nxt;
        end
    end
endmodule

// File: tb/tb_uart_apb_fifo.sv
// Directed self-checking bench for uart_apb_fifo (default parameters, parity macro undefined).
module tb_uart_apb_fifo;
    logic pclk;
    logic rst;
    logic ser_in;
    logic ser_out;
    logic irq;
    logic loopback;
    logic line;
    logic last_rdy;
    int   n_cmp;
    int   n_err;

    uart_apb_fifo_if bus ();

    uart_apb_fifo dut (
        .pclk   (pclk),
        .rst    (rst),
        .apb    (bus.slave),
        .ser_in (ser_in),
        .ser_out(ser_out),
        .irq    (irq)
    );

    assign ser_in = loopback ? ser_out : line;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
        @(posedge pclk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.padd = a; bus.pwdata = d;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        #1;
        err      = bus.pslverr;
        last_rdy = bus.pready;
        @(posedge pclk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
        @(posedge pclk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.padd = a;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        #1;
        d        = bus.prdata;
        err      = bus.pslverr;
        last_rdy = bus.pready;
        @(posedge pclk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    task automatic wait_tx_start(input int budget);
        int k;
        k = 0;
        while (ser_out !== 1'b0 && k < budget) begin
            @(negedge pclk);
            k++;
        end
        check("tx_start_seen", 32'(ser_out), 32'd0);
    endtask

    // One 8N1 frame on ser_in at 16 pclk per bit (DIV=0).
    task automatic send_frame(input logic [7:0] d, input logic stop);
        @(posedge pclk); #1;
        line = 1'b0;
        repeat (16) @(posedge pclk);
        #1;
        for (int i = 0; i < 8; i++) begin
            line = d[i];
            repeat (16) @(posedge pclk);
            #1;
        end
        line = stop;
        repeat (16) @(posedge pclk);
        #1;
        line = 1'b1;
        repeat (4) @(posedge pclk);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [9:0]  frame_a5;
        logic [7:0]  exp8;
        logic        prev;
        int          falls;

        n_cmp = 0; n_err = 0;
        loopback = 1'b0; line = 1'b1; last_rdy = 1'b0;
        bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b0;
        bus.padd = 32'h4; bus.pwdata = '0;
        rst = 1'b1;
        #12;
        check("rst_pready",  32'(bus.pready),  32'd0);
        check("rst_pslverr", 32'(bus.pslverr), 32'd0);
        check("rst_prdata",  bus.prdata,       32'd0);
        check("rst_ser_out", 32'(ser_out),     32'd1);
        check("rst_irq",     32'(irq),         32'd0);
        bus.psel = 1'b0; bus.penable = 1'b0;
        @(negedge pclk);
        rst = 1'b0;

        apb_read(32'h4, rd, er);  check("status_reset", rd, 32'h0A);
        check("pready_access", 32'(last_rdy), 32'd1);
        apb_read(32'h8, rd, er);  check("div_reset", rd, 32'd0);
        apb_read(32'hC, rd, er);  check("ctrl_reset", rd, 32'd0);
        apb_read(32'h10, rd, er); check("bad_addr_slverr", 32'(er), 32'd1);
        check("bad_addr_prdata", rd, 32'd0);
        apb_read(32'h0, rd, er);  check("rx_empty_slverr", 32'(er), 32'd1);
        check("rx_empty_prdata", rd, 32'd0);
        apb_write(32'hC, 32'hFFFF_FF80, er);
        apb_read(32'hC, rd, er);  check("ctrl_unused_zero", rd, 32'd0);

        // 0xA5 frame at DIV=0: start, 1,0,1,0,0,1,0,1, stop.
        frame_a5 = 10'b1_1010_0101_0;
        apb_write(32'hC, 32'h1, er);
        apb_write(32'h0, 32'hA5, er);
        wait_tx_start(50);
        for (int b = 0; b < 10; b++) begin
            repeat ((b == 0) ? 8 : 16) @(negedge pclk);
            check($sformatf("tx_a5_bit%0d", b), 32'(ser_out), 32'(frame_a5[b]));
        end
        apb_read(32'h4, rd, er);  check("status_tx_busy", rd, 32'h8A);
        repeat (20) @(negedge pclk);
        apb_read(32'h4, rd, er);  check("status_tx_done", rd, 32'h0A);

        apb_write(32'hC, 32'h9, er);
        repeat (2) @(negedge pclk);
        check("irq_tx_ie", 32'(irq), 32'd1);
        apb_write(32'hC, 32'h1, er);
        repeat (2) @(negedge pclk);
        check("irq_tx_ie_off", 32'(irq), 32'd0);

        // Overfill TX FIFO with 0xFF so each frame has exactly one falling edge.
        apb_write(32'hC, 32'h0, er);
        for (int i = 0; i < 17; i++) begin
            apb_write(32'h0, 32'hFF, er);
            if (i == 15) check("tx_16th_accepted", 32'(er), 32'd0);
            if (i == 16) check("tx_overflow_slverr", 32'(er), 32'd1);
        end
        apb_read(32'h4, rd, er);  check("status_tx_full", rd, 32'h09);
        apb_write(32'hC, 32'h1, er);
        falls = 0;
        prev  = ser_out;
        for (int k = 0; k < 2800; k++) begin
            @(negedge pclk);
            if (prev && !ser_out) falls++;
            prev = ser_out;
        end
        check("tx_frame_count", 32'(falls), 32'd16);
        apb_read(32'h4, rd, er);  check("status_after_burst", rd, 32'h0A);

        // DIV=3: each bit lasts 64 cycles; char 0x01.
        apb_write(32'h8, 32'h3, er);
        apb_read(32'h8, rd, er);  check("div_readback", rd, 32'h3);
        apb_write(32'h0, 32'h01, er);
        wait_tx_start(50);
        repeat (32) @(negedge pclk); check("div3_start", 32'(ser_out), 32'd0);
        repeat (64) @(negedge pclk); check("div3_bit0",  32'(ser_out), 32'd1);
        repeat (64) @(negedge pclk); check("div3_bit1",  32'(ser_out), 32'd0);
        repeat (520) @(negedge pclk);
        apb_write(32'h8, 32'h0, er);
        apb_read(32'h4, rd, er);  check("status_after_div3", rd, 32'h0A);

        // Loopback 0x3C with rx_ie.
        loopback = 1'b1;
        apb_write(32'hC, 32'h7, er);
        apb_write(32'h0, 32'h3C, er);
        check("irq_before_rx", 32'(irq), 32'd0);
        repeat (200) @(negedge pclk);
        check("irq_rx_ready", 32'(irq), 32'd1);
        apb_read(32'h4, rd, er);  check("status_rx_ready", rd, 32'h02);
        apb_read(32'h0, rd, er);  check("loopback_data", rd, 32'h3C);
        check("loopback_slverr", 32'(er), 32'd0);
        repeat (2) @(negedge pclk);
        check("irq_after_read", 32'(irq), 32'd0);
        loopback = 1'b0;

        // Framing error: 0x55 with stop bit 0.
        apb_write(32'hC, 32'h12, er);
        send_frame(8'h55, 1'b0);
        repeat (10) @(negedge pclk);
        check("irq_frame_err", 32'(irq), 32'd1);
        apb_read(32'h4, rd, er);  check("status_frame_err", rd, 32'h2A);
        apb_write(32'h4, 32'h20, er);
        apb_read(32'h4, rd, er);  check("status_fe_cleared", rd, 32'h0A);
        repeat (2) @(negedge pclk);
        check("irq_fe_cleared", 32'(irq), 32'd0);

        // Overrun: 17 characters into a 16-entry RX FIFO.
        apb_write(32'hC, 32'h2, er);
        for (int i = 0; i < 17; i++) begin
            exp8 = 8'(i * 17 + 3);
            send_frame(exp8, 1'b1);
        end
        apb_read(32'h4, rd, er);  check("status_overrun", rd, 32'h16);
        for (int i = 0; i < 16; i++) begin
            exp8 = 8'(i * 17 + 3);
            apb_read(32'h0, rd, er);
            check($sformatf("rx_fifo_%0d", i), rd, 32'(exp8));
        end
        apb_read(32'h0, rd, er);  check("rx_drained_slverr", 32'(er), 32'd1);
        apb_write(32'h4, 32'h10, er);
        apb_read(32'h4, rd, er);  check("status_ovr_cleared", rd, 32'h0A);

        // Reset during data bit 4 of a 0x00 frame.
        apb_write(32'hC, 32'h9, er);
        apb_write(32'h0, 32'h00, er);
        wait_tx_start(50);
        repeat (88) @(negedge pclk);
        check("pre_rst_ser_out", 32'(ser_out), 32'd0);
        check("pre_rst_irq",     32'(irq),     32'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_ser_out", 32'(ser_out), 32'd1);
        check("mid_rst_irq",     32'(irq),     32'd0);
        repeat (3) @(negedge pclk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apb_read(32'h4, rd, er);
            check($sformatf("post_rst_status_%0d", i), rd, 32'h0A);
            repeat (50) @(negedge pclk);
        end
        apb_read(32'hC, rd, er);  check("post_rst_ctrl", rd, 32'd0);
        check("post_rst_ser_out", 32'(ser_out), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
